banked_memory_ctrl: RTL and testbench

Next-generation memory subsystem for the core: a banked instruction ROM with a multi-word fetch port, plus data RAM and VRAM behind a handshaked data port, all usable in the same cycle. Adds an independent VRAM read port for the display scanner. Adds a post-reset VRAM clear sequencer. Sits between the core pipeline (fetch/load-store) and the video block.

---
 rtl/banked_memory_ctrl_if.sv | 36 +++
 rtl/banked_memory_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_banked_memory_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/banked_memory_ctrl_if.sv
// Bus bundle for banked_memory_ctrl: fetch, data and display ports plus the clear-busy flag.
// The master side is the core/video, and the slave side is the memory controller.
interface banked_memory_ctrl_if #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int FETCH_WORDS = 2,
    parameter int VRAM_AW     = 15
);
    logic                          f_req;
    logic [ADDR_W-1:0]             f_addr;
    logic                          f_valid;
    logic [FETCH_WORDS*DATA_W-1:0] f_data;

    logic                          d_req;
    logic                          d_we;
    logic [ADDR_W-1:0]             d_addr;
    logic [DATA_W-1:0]             d_wdata;
    logic                          d_ready;
    logic                          d_rvalid;
    logic [DATA_W-1:0]             d_rdata;

    logic [VRAM_AW-1:0]            v_addr;
    logic [DATA_W-1:0]             v_data;

    logic                          busy;

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, v_addr,
        input  f_valid, f_data, d_ready, d_rvalid, d_rdata, v_data, busy
    );

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, v_addr,
        output f_valid, f_data, d_ready, d_rvalid, d_rdata, v_data, busy
    );
endinterface

// File: rtl/banked_memory_ctrl.sv
// Banked instruction ROM with a multi-word fetch port. Data RAM and VRAM sit behind a handshaked data port, and VRAM also has a display read port.
// Defining VRAM_CLEAR_EN adds a post-reset VRAM clear sequencer that holds off the data port while it runs.
module banked_memory_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int FETCH_WORDS = 2,
    parameter int ROM_AW      = 15,
    parameter int RAM_AW      = 15,
    parameter int VRAM_AW     = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    banked_memory_ctrl_if.slave  bus
);
    localparam int LOG_FW     = $clog2(FETCH_WORDS);
    localparam int LSB_W      = (LOG_FW > 0) ? LOG_FW : 1;
    localparam int BANK_AW    = ROM_AW - LOG_FW;
    localparam int BANK_DEPTH = 2 ** BANK_AW;

    // Bank b holds ROM words whose address mod FETCH_WORDS == b. Contents come from init only.
    logic [DATA_W-1:0] rom_mem  [FETCH_WORDS][BANK_DEPTH];
    logic [DATA_W-1:0] ram_mem  [2**RAM_AW];
    logic [DATA_W-1:0] vram_mem [2**VRAM_AW];

    logic                busy;
    logic                d_ready;
    logic                clr_we;
    logic [VRAM_AW-1:0]  clr_cnt;

    // ---------------- stage p0: fetch address split ----------------
    logic [ROM_AW-1:0]   f_word_p0;
    logic [LSB_W-1:0]    f_lsb_p0;
    logic [BANK_AW-1:0]  bank_idx_p0 [FETCH_WORDS];

    assign f_word_p0 = bus.f_addr[ROM_AW-1:0];
    assign f_lsb_p0  = LSB_W'(f_word_p0 & ROM_AW'(FETCH_WORDS - 1));

    // Banks below the start bank hold words from the next row, and the row index wraps at the ROM top.
    always_comb begin
        for (int b = 0; b < FETCH_WORDS; b++) begin
            bank_idx_p0[b] = BANK_AW'(f_word_p0 >> LOG_FW)
                           + ((b < int'(f_lsb_p0)) ? BANK_AW'(1) : BANK_AW'(0));
        end
    end

    generate
        if (ADDR_W > ROM_AW) begin : g_f_addr_hi
            logic unused_f_addr_hi;
            assign unused_f_addr_hi = ^bus.f_addr[ADDR_W-1:ROM_AW];
        end
    endgenerate

    // ---------------- stage p1: bank reads and rotation ----------------
    logic [DATA_W-1:0] bank_q_p1 [FETCH_WORDS];
    logic [LSB_W-1:0]  f_lsb_p1;
    logic              f_vld_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            f_vld_p1 <= 1'b0;
            f_lsb_p1 <= '0;
            for (int b = 0; b < FETCH_WORDS; b++) bank_q_p1[b] <= '0;
        end else begin
            f_vld_p1 <= bus.f_req;
            if (bus.f_req) begin
                f_lsb_p1 <= f_lsb_p0;
                for (int b = 0; b < FETCH_WORDS; b++) bank_q_p1[b] <= rom_mem[b][bank_idx_p0[b]];
            end
        end
    end

    always_comb begin
        bus.f_data = '0;
        for (int i = 0; i < FETCH_WORDS; i++) begin
            bus.f_data[i*DATA_W +: DATA_W] = bank_q_p1[(int'(f_lsb_p1) + i) % FETCH_WORDS];
        end
    end

    assign bus.f_valid = f_vld_p1;

    // ---------------- stage p0: data port decode ----------------
    logic               d_vram_p0;
    logic               d_xfer_p0;
    logic               d_wr_p0;
    logic               d_rd_p0;
    logic               vram_we_p0;
    logic [VRAM_AW-1:0] vram_wa_p0;
    logic [DATA_W-1:0]  vram_wd_p0;

    assign d_vram_p0  = bus.d_addr[ADDR_W-1];
    assign d_xfer_p0  = bus.d_req && d_ready;
    assign d_wr_p0    = d_xfer_p0 && bus.d_we;
    assign d_rd_p0    = d_xfer_p0 && !bus.d_we;

    // The clear sequencer owns the VRAM write port while busy, and d_ready is low then.
    assign vram_we_p0 = clr_we || (d_wr_p0 && d_vram_p0);
    assign vram_wa_p0 = clr_we ? clr_cnt : bus.d_addr[VRAM_AW-1:0];
    assign vram_wd_p0 = clr_we ? '0 : bus.d_wdata;

    always_ff @(posedge clk) begin
        if (d_wr_p0 && !d_vram_p0) ram_mem[bus.d_addr[RAM_AW-1:0]] <= bus.d_wdata;
    end

    always_ff @(posedge clk) begin
        if (vram_we_p0) vram_mem[vram_wa_p0] <= vram_wd_p0;
    end

    // ---------------- stage p1: data and display read registers ----------------
    logic              d_rvld_p1;
    logic [DATA_W-1:0] d_rdata_p1;
    logic [DATA_W-1:0] v_data_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_rvld_p1  <= 1'b0;
            d_rdata_p1 <= '0;
        end else begin
            d_rvld_p1 <= d_rd_p0;
            if (d_rd_p0) begin
                d_rdata_p1 <= d_vram_p0 ? vram_mem[bus.d_addr[VRAM_AW-1:0]]
                                        : ram_mem[bus.d_addr[RAM_AW-1:0]];
            end
        end
    end

    // The display read sees the pre-write contents when the same word is written in this cycle.
    always_ff @(posedge clk) begin
        if (rst) v_data_p1 <= '0;
        else     v_data_p1 <= vram_mem[bus.v_addr];
    end

    assign bus.d_rvalid = d_rvld_p1;
    assign bus.d_rdata  = d_rdata_p1;
    assign bus.v_data   = v_data_p1;

`ifdef VRAM_CLEAR_EN
    typedef enum logic {S_IDLE, S_CLEAR} clr_state_t;

    clr_state_t clr_state, clr_state_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_state <= S_CLEAR;
            clr_cnt   <= '0;
        end else begin
            clr_state <= clr_state_nx;
            if (clr_state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        clr_state_nx = clr_state;
        case (clr_state)
            S_CLEAR: if (clr_cnt == '1) clr_state_nx = S_IDLE;
            default: clr_state_nx = clr_state;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        clr_we = 1'b0;
        case (clr_state)
            S_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
            end
            default: ;
        endcase
    end
`else
    assign busy    = 1'b0;
    assign clr_we  = 1'b0;
    assign clr_cnt = '0;
`endif

    assign d_ready  = !busy;
    assign bus.d_ready = d_ready;
    assign bus.busy    = busy;

endmodule

// File: tb/tb_banked_memory_ctrl.sv
// Directed-vector bench for banked_memory_ctrl: fetch banking and wrap, data region decode, display read-first, concurrency.
// With VRAM_CLEAR_EN it also covers the clear sequencer, using VRAM_AW=4.
module tb_banked_memory_ctrl;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int FETCH_WORDS = 2;
    localparam int ROM_AW      = 15;
    localparam int RAM_AW      = 15;
`ifdef VRAM_CLEAR_EN
    localparam int VRAM_AW     = 4;
`else
    localparam int VRAM_AW     = 15;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    banked_memory_ctrl_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FETCH_WORDS(FETCH_WORDS), .VRAM_AW(VRAM_AW)
    ) bus ();

    banked_memory_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FETCH_WORDS(FETCH_WORDS),
        .ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .VRAM_AW(VRAM_AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic data_op(input logic we, input logic [15:0] addr, input logic [15:0] wd);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wd;
    endtask

`ifdef VRAM_CLEAR_EN
    task automatic count_busy(input string tag);
        int n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk(tag, 64'(n), 64'd16);
    endtask
`endif

    initial begin
        for (int k = 0; k < (1 << ROM_AW); k++) begin
            dut.rom_mem[k % FETCH_WORDS][k / FETCH_WORDS] = 16'(k + 'h100);
        end

        bus.f_req = 1'b0; bus.f_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.v_addr = '0;

        rst = 1'b1;
        step();
        step();
        chk("rst_f_valid",  64'(bus.f_valid),  64'd0);
        chk("rst_f_data",   64'(bus.f_data),   64'd0);
        chk("rst_d_rvalid", 64'(bus.d_rvalid), 64'd0);
        chk("rst_d_rdata",  64'(bus.d_rdata),  64'd0);
        chk("rst_v_data",   64'(bus.v_data),   64'd0);
`ifdef VRAM_CLEAR_EN
        chk("rst_busy",     64'(bus.busy),     64'd1);
        chk("rst_d_ready",  64'(bus.d_ready),  64'd0);
`else
        chk("rst_busy",     64'(bus.busy),     64'd0);
        chk("rst_d_ready",  64'(bus.d_ready),  64'd1);
`endif
        rst = 1'b0;

`ifdef VRAM_CLEAR_EN
        count_busy("clear_len");
        chk("clear_d_ready", 64'(bus.d_ready), 64'd1);
        for (int k = 0; k < 16; k++) begin
            bus.v_addr = VRAM_AW'(k);
            step();
            chk("clear_zero", 64'(bus.v_data), 64'd0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 7; k++) step();
        chk("clear_mid_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy("clear_restart_len");
`endif

        bus.f_req = 1'b1; bus.f_addr = 16'h0005;
        step();
        chk("fetch5_valid", 64'(bus.f_valid), 64'd1);
        chk("fetch5_data",  64'(bus.f_data),  64'h0106_0105);
        bus.f_addr = 16'h0004;
        step();
        chk("fetch4_data",  64'(bus.f_data),  64'h0105_0104);
        bus.f_addr = 16'h7FFF;
        step();
        chk("fetch_wrap",   64'(bus.f_data),  64'h0100_80FF);
        bus.f_addr = 16'hFFFE;
        step();
        chk("fetch_hibit",  64'(bus.f_data),  64'h80FF_80FE);
        bus.f_req = 1'b0; bus.f_addr = 16'h0002;
        step();
        chk("fetch_idle_valid", 64'(bus.f_valid), 64'd0);
        chk("fetch_idle_hold",  64'(bus.f_data),  64'h80FF_80FE);

        data_op(1'b1, 16'h0010, 16'hBEEF);
        step();
        chk("wr_rvalid",   64'(bus.d_rvalid), 64'd0);
        chk("wr_rdata",    64'(bus.d_rdata),  64'd0);
        data_op(1'b0, 16'h0010, 16'h0000);
        step();
        chk("rd_rvalid",   64'(bus.d_rvalid), 64'd1);
        chk("rd_ram",      64'(bus.d_rdata),  64'hBEEF);
        data_op(1'b1, 16'h8010, 16'h1234);
        step();
        chk("wrv_rvalid",  64'(bus.d_rvalid), 64'd0);
        chk("wrv_hold",    64'(bus.d_rdata),  64'hBEEF);
        data_op(1'b0, 16'h0010, 16'h0000);
        step();
        chk("rd_ram_kept", 64'(bus.d_rdata),  64'hBEEF);
        data_op(1'b0, 16'h8010, 16'h0000);
        step();
        chk("rd_vram",     64'(bus.d_rdata),  64'h1234);
        bus.d_req = 1'b0;
        bus.v_addr = VRAM_AW'(16'h0010);
        step();
        chk("idle_rvalid", 64'(bus.d_rvalid), 64'd0);
        chk("idle_hold",   64'(bus.d_rdata),  64'h1234);
        chk("disp_vram",   64'(bus.v_data),   64'h1234);

        data_op(1'b1, 16'h8003, 16'h1111);
        step();
        data_op(1'b1, 16'h8003, 16'h2222);
        bus.v_addr = VRAM_AW'(3);
        step();
        chk("rf_old",      64'(bus.v_data),   64'h1111);
        bus.d_req = 1'b0;
        step();
        chk("rf_new",      64'(bus.v_data),   64'h2222);

        bus.f_req = 1'b1; bus.f_addr = 16'h0100;
        data_op(1'b0, 16'h0010, 16'h0000);
        bus.v_addr = VRAM_AW'(3);
        step();
        chk("cc_f_valid",  64'(bus.f_valid),  64'd1);
        chk("cc_f_data",   64'(bus.f_data),   64'h0201_0200);
        chk("cc_d_rvalid", 64'(bus.d_rvalid), 64'd1);
        chk("cc_d_rdata",  64'(bus.d_rdata),  64'hBEEF);
        chk("cc_v_data",   64'(bus.v_data),   64'h2222);
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        step();
        chk("cc_end_f_valid", 64'(bus.f_valid),  64'd0);
        chk("cc_end_rvalid",  64'(bus.d_rvalid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
